// File: rtl/approx_lut_ctrl.sv
// Bank of programmable 5-input approximate-logic LUTs. Handles truth-table loading,
// single-cycle lookups, and a 32-cycle sweep that grades a LUT against a golden table.
module approx_lut_ctrl #(
    parameter int          N_LUT    = 4,
    parameter int          SEL_W    = 2,
    parameter logic [31:0] RESET_TT = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [31:0]      cfg_data,
    output logic             cfg_drop,
    input  logic             eval_valid,
    output logic             eval_ready,
    input  logic [SEL_W-1:0] eval_sel,
    input  logic [4:0]       eval_in,
    output logic             res_valid,
    output logic             res_out,
    output logic             res_err,
    input  logic             sweep_start,
    input  logic [SEL_W-1:0] sweep_sel,
    input  logic [31:0]      sweep_golden,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [5:0]       err_count,
    output logic [31:0]      err_mask
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [SEL_W:0] LP_N_LUT = (SEL_W + 1)'(N_LUT);

    logic [31:0]      r_tt [N_LUT];
    logic [1:0]       r_state;
    logic [4:0]       r_idx;
    logic [SEL_W-1:0] r_sweep_sel;
    logic [31:0]      r_golden;
    logic [5:0]       r_err_count;
    logic [31:0]      r_err_mask;
    logic             r_cfg_drop;
    logic             r_res_valid;
    logic             r_res_out;
    logic             r_res_err;

    logic        w_idle;
    logic        w_cfg_ok;
    logic        w_eval_acc;
    logic        w_eval_inrange;
    logic        w_sweep_go;
    logic [31:0] w_eval_tt;
    logic [31:0] w_sweep_tt;
    logic        w_sweep_miss;

    assign w_idle         = (r_state == S_IDLE);
    assign w_cfg_ok       = cfg_we && w_idle && ({1'b0, cfg_sel} < LP_N_LUT);
    assign w_eval_acc     = eval_valid && eval_ready;
    assign w_eval_inrange = ({1'b0, eval_sel} < LP_N_LUT);
    assign w_sweep_go     = sweep_start && w_idle && ({1'b0, sweep_sel} < LP_N_LUT);

    // Explicit select loops keep out-of-range indices from ever addressing the array.
    always_comb begin
        w_eval_tt  = '0;
        w_sweep_tt = '0;
        for (int i = 0; i < N_LUT; i++) begin
            if (eval_sel == i[SEL_W-1:0])
                w_eval_tt = r_tt[i];
            if (r_sweep_sel == i[SEL_W-1:0])
                w_sweep_tt = r_tt[i];
        end
    end

    assign w_sweep_miss = (w_sweep_tt[r_idx] != r_golden[r_idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_LUT; i++)
                r_tt[i] <= RESET_TT;
        end else begin
            for (int i = 0; i < N_LUT; i++)
                if (w_cfg_ok && (cfg_sel == i[SEL_W-1:0]))
                    r_tt[i] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_drop  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_out   <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            r_cfg_drop  <= cfg_we && !w_cfg_ok;
            r_res_valid <= w_eval_acc;
            // Reads the pre-write table, so a same-edge cfg write is not visible here.
            if (w_eval_acc) begin
                r_res_out <= w_eval_inrange ? w_eval_tt[eval_in] : 1'b0;
                r_res_err <= !w_eval_inrange;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_sweep_sel <= '0;
            r_golden    <= '0;
            r_err_count <= '0;
            r_err_mask  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sweep_go) begin
                        r_state     <= S_SWEEP;
                        r_idx       <= '0;
                        r_sweep_sel <= sweep_sel;
                        r_golden    <= sweep_golden;
                        r_err_count <= '0;
                        r_err_mask  <= '0;
                    end
                end
                S_SWEEP: begin
                    if (w_sweep_miss) begin
                        r_err_mask[r_idx] <= 1'b1;
                        r_err_count       <= r_err_count + 6'd1;
                    end
                    r_idx <= r_idx + 5'd1;
                    if (r_idx == 5'd31)
                        r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign eval_ready = w_idle && !rst;
    assign cfg_drop   = r_cfg_drop;
    assign res_valid  = r_res_valid;
    assign res_out    = r_res_out;
    assign res_err    = r_res_err;
    assign sweep_busy = (r_state == S_SWEEP);
    assign sweep_done = (r_state == S_DONE);
    assign err_count  = r_err_count;
    assign err_mask   = r_err_mask;

endmodule

// File: tb/tb_approx_lut_ctrl.sv
// Directed bench for approx_lut_ctrl with a 3-LUT bank so that select 3 is out of range.
module tb_approx_lut_ctrl;

    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [SEL_W-1:0] cfg_sel = '0;
    logic [31:0]      cfg_data = '0;
    logic             cfg_drop;
    logic             eval_valid = 1'b0;
    logic             eval_ready;
    logic [SEL_W-1:0] eval_sel = '0;
    logic [4:0]       eval_in = '0;
    logic             res_valid;
    logic             res_out;
    logic             res_err;
    logic             sweep_start = 1'b0;
    logic [SEL_W-1:0] sweep_sel = '0;
    logic [31:0]      sweep_golden = '0;
    logic             sweep_busy;
    logic             sweep_done;
    logic [5:0]       err_count;
    logic [31:0]      err_mask;

    int vecs = 0;
    int miss = 0;
    int n_busy;
    int n_done;

    approx_lut_ctrl #(.N_LUT(3), .SEL_W(SEL_W), .RESET_TT(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_drop(cfg_drop),
        .eval_valid(eval_valid), .eval_ready(eval_ready), .eval_sel(eval_sel), .eval_in(eval_in),
        .res_valid(res_valid), .res_out(res_out), .res_err(res_err),
        .sweep_start(sweep_start), .sweep_sel(sweep_sel), .sweep_golden(sweep_golden),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .err_count(err_count), .err_mask(err_mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic eval_one(input logic [1:0] sel, input logic [4:0] idx);
        eval_valid = 1'b1; eval_sel = sel; eval_in = idx;
        tick();
        eval_valid = 1'b0;
    endtask

    task automatic run_to_done();
        n_busy = 1;
        for (int k = 0; k < 40 && sweep_busy; k++) begin
            tick();
            if (sweep_busy) n_busy++;
        end
    endtask

    initial begin
        tick(); tick();
        chk("rst_busy", 32'(sweep_busy), 32'd0);
        chk("rst_ready", 32'(eval_ready), 32'd0);
        chk("rst_count", 32'(err_count), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(eval_ready), 32'd1);

        // LUT 0 program and lookups
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 32'h8000_0001;
        tick();
        cfg_we = 1'b0;
        chk("cfg0_drop", 32'(cfg_drop), 32'd0);
        eval_valid = 1'b1; eval_sel = 2'd0; eval_in = 5'd0;
        tick();
        chk("ev0_in0_vld", 32'(res_valid), 32'd1);
        chk("ev0_in0_out", 32'(res_out), 32'd1);
        eval_in = 5'd31;
        tick();
        chk("ev0_in31_out", 32'(res_out), 32'd1);
        chk("ev0_in31_vld", 32'(res_valid), 32'd1);
        eval_in = 5'd5;
        tick();
        eval_valid = 1'b0;
        chk("ev0_in5_out", 32'(res_out), 32'd0);
        chk("ev0_in5_err", 32'(res_err), 32'd0);
        tick();
        chk("idle_vld", 32'(res_valid), 32'd0);

        // Matching sweep on LUT 1
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 32'hCAFE_F00D;
        tick();
        cfg_we = 1'b0;
        sweep_start = 1'b1; sweep_sel = 2'd1; sweep_golden = 32'hCAFE_F00D;
        tick();
        sweep_start = 1'b0;
        chk("sw1_busy_e0", 32'(sweep_busy), 32'd1);
        chk("sw1_ready", 32'(eval_ready), 32'd0);
        run_to_done();
        chk("sw1_busy_cycles", 32'(n_busy), 32'd32);
        chk("sw1_done", 32'(sweep_done), 32'd1);
        chk("sw1_count", 32'(err_count), 32'd0);
        chk("sw1_mask", err_mask, 32'd0);
        tick();
        chk("sw1_done_pulse", 32'(sweep_done), 32'd0);
        chk("sw1_ready_back", 32'(eval_ready), 32'd1);

        // Mismatching sweep with write/eval attempts while busy
        sweep_start = 1'b1; sweep_golden = 32'hCAFC_F005;
        tick();
        sweep_start = 1'b0;
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 32'h0000_0000;
        eval_valid = 1'b1; eval_sel = 2'd1; eval_in = 5'd3;
        chk("sw2_ready_busy", 32'(eval_ready), 32'd0);
        tick();
        cfg_we = 1'b0; eval_valid = 1'b0;
        chk("sw2_drop", 32'(cfg_drop), 32'd1);
        chk("sw2_no_res", 32'(res_valid), 32'd0);
        n_busy = 2;
        for (int k = 0; k < 40 && sweep_busy; k++) begin
            tick();
            if (sweep_busy) n_busy++;
            if (k == 1) chk("sw2_drop_pulse", 32'(cfg_drop), 32'd0);
        end
        chk("sw2_busy_cycles", 32'(n_busy), 32'd32);
        chk("sw2_done", 32'(sweep_done), 32'd1);
        chk("sw2_count", 32'(err_count), 32'd2);
        chk("sw2_mask", err_mask, 32'h0002_0008);
        tick();
        chk("sw2_hold_count", 32'(err_count), 32'd2);
        eval_one(2'd1, 5'd3);
        chk("tt1_kept_b3", 32'(res_out), 32'd1);
        eval_one(2'd1, 5'd1);
        chk("tt1_kept_b1", 32'(res_out), 32'd0);

        // Out-of-range selects
        eval_one(2'd3, 5'd0);
        chk("oor_err", 32'(res_err), 32'd1);
        chk("oor_out", 32'(res_out), 32'd0);
        cfg_we = 1'b1; cfg_sel = 2'd3; cfg_data = 32'hFFFF_FFFF;
        tick();
        cfg_we = 1'b0;
        chk("oor_drop", 32'(cfg_drop), 32'd1);
        sweep_start = 1'b1; sweep_sel = 2'd3;
        tick();
        sweep_start = 1'b0;
        chk("oor_sweep_ignored", 32'(sweep_busy), 32'd0);

        // Write + eval + sweep_start on the same edge
        cfg_we = 1'b1; cfg_sel = 2'd2; cfg_data = 32'h0000_FFFF;
        eval_valid = 1'b1; eval_sel = 2'd0; eval_in = 5'd0;
        sweep_start = 1'b1; sweep_sel = 2'd2; sweep_golden = 32'h0000_0000;
        tick();
        cfg_we = 1'b0; eval_valid = 1'b0; sweep_start = 1'b0;
        chk("simul_res_vld", 32'(res_valid), 32'd1);
        chk("simul_res_out", 32'(res_out), 32'd1);
        chk("simul_busy", 32'(sweep_busy), 32'd1);
        run_to_done();
        chk("simul_count", 32'(err_count), 32'd16);
        chk("simul_mask", err_mask, 32'h0000_FFFF);
        tick();

        // Reset in the middle of a sweep
        sweep_start = 1'b1; sweep_sel = 2'd1; sweep_golden = 32'h0000_0000;
        tick();
        sweep_start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("mid_count_nz", 32'(err_count != 6'd0), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(sweep_busy), 32'd0);
        chk("abort_count", 32'(err_count), 32'd0);
        chk("abort_mask", err_mask, 32'd0);
        tick();
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (sweep_done) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        eval_one(2'd0, 5'd0);
        chk("abort_tt0", 32'(res_out), 32'd0);
        eval_one(2'd1, 5'd2);
        chk("abort_tt1", 32'(res_out), 32'd0);
        eval_one(2'd2, 5'd4);
        chk("abort_tt2", 32'(res_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
